// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared DMType encodings, responder states and type helpers.
package dmem_responder_pkg;

    typedef enum logic [2:0] {
        DM_WORD              = 3'b000,
        DM_HALFWORD          = 3'b001,
        DM_HALFWORD_UNSIGNED = 3'b010,
        DM_BYTE              = 3'b011,
        DM_BYTE_UNSIGNED     = 3'b100
    } dmtype_e;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_WRITE, S_RESP} state_e;

    function automatic logic is_half(input logic [2:0] t);
        return t == DM_HALFWORD || t == DM_HALFWORD_UNSIGNED;
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: store byte-lane merge and load lane extraction with sign/zero extension.
module dm_lane_unit
    import dmem_responder_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  dmtype_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [3:0]  be;
    logic [31:0] wd;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        be = dmtype_i == DM_WORD ? 4'hF : is_half(dmtype_i) ? (off_i[1] ? 4'hC : 4'h3) : 4'b0001 << off_i;
        wd = dmtype_i == DM_WORD ? wdata_i : is_half(dmtype_i) ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
        merged_o = word_i;
        for (int i = 0; i < 4; i++) merged_o[8*i +: 8] = be[i] ? wd[8*i +: 8] : word_i[8*i +: 8];
        b = word_i[{off_i, 3'b000} +: 8];
        h = off_i[1] ? word_i[31:16] : word_i[15:0];
        load_o = dmtype_i == DM_WORD              ? word_i :
                 dmtype_i == DM_HALFWORD          ? {{16{h[15]}}, h} :
                 dmtype_i == DM_HALFWORD_UNSIGNED ? {16'd0, h} :
                 dmtype_i == DM_BYTE              ? {{24{b[7]}}, b} :
                 dmtype_i == DM_BYTE_UNSIGNED     ? {24'd0, b} : 32'd0;
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage load/store responder with wait states and read-modify-write sub-word stores.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_dmtype,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CLAST = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            we_q;
    logic [31:0]     addr_q, wdata_q, buf_q;
    logic [2:0]      type_q;
    logic            legal;
    logic [31:0]     merged, load, rdata_d;
    logic [31:0]     mem_q [2**ADDR_WIDTH];

    function automatic logic ok(input logic [31:0] a, input logic [2:0] t);
        return t <= 3'd4 && (a >> (ADDR_WIDTH + 2)) == 32'd0 &&
               !(t == DM_WORD && a[1:0] != 2'b00) && !(is_half(t) && a[0]);
    endfunction

    dm_lane_unit u_lane (
        .word_i  (buf_q),
        .off_i   (addr_q[1:0]),
        .dmtype_i(type_q),
        .wdata_i (wdata_q),
        .merged_o(merged),
        .load_o  (load)
    );

    always_comb begin
        legal   = ok(addr_q, type_q);
        rdata_d = legal && !we_q ? load : 32'd0;
    end

    assign req_ready = state_q == S_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            type_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                S_IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    type_q  <= req_dmtype;
                    cnt_q   <= '0;
                    state_q <= WAIT_CYCLES > 0 ? S_WAIT : ok(req_addr, req_dmtype) ? S_READ : S_RESP;
                end
                S_WAIT: if (cnt_q == CLAST) state_q <= legal ? S_READ : S_RESP;
                        else cnt_q <= cnt_q + 1'b1;
                S_READ:  state_q <= we_q ? S_WRITE : S_RESP;
                S_WRITE: state_q <= S_RESP;
                S_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= rdata_d;
                    rsp_err   <= !legal;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Array has no reset; the async-reset FSM never reaches READ/WRITE while reset is held.
    always_ff @(posedge clk) begin
        if (state_q == S_READ) buf_q <= mem_q[addr_q[ADDR_WIDTH+1:2]];
        if (state_q == S_WRITE) mem_q[addr_q[ADDR_WIDTH+1:2]] <= merged;
    end

endmodule
